// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, the icache refill path, the core data port and main memory.
interface mem_arbiter_if;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;

  logic          ic_mreq;
  logic [AW-1:0] ic_addr;
  logic          ic_clk_en;
  logic [DW-1:0] ic_rdata;

  logic          dp_req;
  logic          dp_we;
  logic [AW-1:0] dp_addr;
  logic [DW-1:0] dp_wdata;
  logic [DW-1:0] dp_rdata;
  logic          dp_ready;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  ic_mreq, ic_addr, dp_req, dp_we, dp_addr, dp_wdata, mem_rdata,
    output ic_clk_en, ic_rdata, dp_rdata, dp_ready, mem_addr, mem_we, mem_wdata
  );

  // Requester / memory view
  modport master (
    output ic_mreq, ic_addr, dp_req, dp_we, dp_addr, dp_wdata, mem_rdata,
    input  ic_clk_en, ic_rdata, dp_rdata, dp_ready, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for single-port main memory: icache line refills are locked
// for as long as ic_mreq stays high, data accesses are fixed 2-cycle transactions.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IC_BURST = 2'd1,
    DP_ADDR  = 2'd2,
    DP_DATA  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_grant;      // 0 = icache won last, 1 = data port won last
  logic   last_grant_nxt;
  logic   dp_win;

  // Next-state and round-robin decision
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    dp_win         = bus.dp_req && (!bus.ic_mreq || !last_grant);
    case (state)
      IDLE: begin
        if (dp_win) begin
          state_nxt      = DP_ADDR;
          last_grant_nxt = 1'b1;
        end else if (bus.ic_mreq) begin
          state_nxt      = IC_BURST;
          last_grant_nxt = 1'b0;
        end
      end
      IC_BURST: if (!bus.ic_mreq) state_nxt = IDLE;
      DP_ADDR:  state_nxt = DP_DATA;
      DP_DATA:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b0;
    end else if (clk_en) begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Memory steering decoded from the registered state
  always_comb begin
    bus.mem_addr = '0;
    bus.mem_we   = 1'b0;
    bus.dp_ready = 1'b0;
    case (state)
      IC_BURST: bus.mem_addr = bus.ic_addr;
      DP_ADDR: begin
        bus.mem_addr = bus.dp_addr;
        bus.mem_we   = bus.dp_we;
      end
      DP_DATA: begin
        bus.mem_addr = bus.dp_addr;
        bus.dp_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // A pending but ungranted miss freezes the icache
  assign bus.ic_clk_en = clk_en && ((state == IC_BURST) || !bus.ic_mreq);
  assign bus.ic_rdata  = bus.mem_rdata;
  assign bus.dp_rdata  = bus.mem_rdata;
  assign bus.mem_wdata = bus.dp_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural memory, a small icache refill model
// and a data-port driver, with hand-derived expected values.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] img(input logic [9:0] a);
    return 16'(a) * 16'd3 + 16'h1000;
  endfunction

  // Synchronous memory, 1-cycle read latency; preloaded on the first edges
  logic [15:0] mem [1024];
  logic        mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= img(10'(i));
      mem[10'h155] <= 16'hBEEF;
      mem_loaded   <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Icache refill: check stage, 16 cycles for 8 words, one release cycle with ic_mreq low
  logic        ic_go;
  logic [9:0]  ic_base;
  logic [4:0]  ic_cnt = 5'd0;
  logic [2:0]  ic_word;
  logic [15:0] ic_line [8];

  always_comb begin
    ic_word = 3'd0;
    if (ic_cnt >= 5'd16) ic_word = 3'd7;
    else if (ic_cnt != 5'd0) ic_word = 3'((ic_cnt - 5'd1) >> 1);
  end
  assign bus.ic_addr = ic_base + 10'(ic_word);
  assign bus.ic_mreq = ic_go && (ic_cnt != 5'd17);

  always @(posedge clk) begin
    if (!ic_go) ic_cnt <= 5'd0;
    else if (bus.ic_clk_en && ic_cnt != 5'd17) begin
      if (ic_cnt >= 5'd2 && !ic_cnt[0]) ic_line[3'((ic_cnt - 5'd2) >> 1)] <= bus.ic_rdata;
      ic_cnt <= ic_cnt + 5'd1;
    end
  end

  // Event counters sampled over each completed cycle
  int frozen_cnt = 0;
  int we_cnt     = 0;
  int track_err  = 0;
  int burst_cnt  = 0;
  always @(posedge clk) begin
    if (rst_n && bus.ic_mreq && !bus.ic_clk_en) frozen_cnt <= frozen_cnt + 1;
    if (bus.mem_we) we_cnt <= we_cnt + 1;
    if (ic_go && bus.ic_mreq && bus.ic_clk_en) begin
      burst_cnt <= burst_cnt + 1;
      if (bus.mem_addr != bus.ic_addr || bus.mem_we) track_err <= track_err + 1;
    end
  end

  // Data-port request fields must stay stable until dp_ready
  logic        p_req = 1'b0, p_rdy = 1'b0, p_we = 1'b0;
  logic [9:0]  p_addr = '0;
  logic [15:0] p_wd = '0;
  always @(posedge clk) begin
    if (rst_n && p_req && !p_rdy && bus.dp_req)
      assert (bus.dp_we == p_we && bus.dp_addr == p_addr && bus.dp_wdata == p_wd)
        else $error("data port protocol violation");
    p_req  <= bus.dp_req;
    p_rdy  <= bus.dp_ready;
    p_we   <= bus.dp_we;
    p_addr <= bus.dp_addr;
    p_wd   <= bus.dp_wdata;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dp_txn(input logic we, input logic [9:0] a, input logic [15:0] wd,
                        output logic [15:0] rd, output int lat);
    bus.dp_req   = 1'b1;
    bus.dp_we    = we;
    bus.dp_addr  = a;
    bus.dp_wdata = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.dp_ready && lat < 60);
    rd = bus.dp_rdata;
    bus.dp_req = 1'b0;
  endtask

  task automatic wait_ic_release(output int n);
    n = 0;
    while (bus.ic_mreq && n < 200) begin
      @(negedge clk);
      n++;
    end
    ic_go = 1'b0;
  endtask

  task automatic check_line(input string tag, input logic [9:0] base);
    int err = 0;
    for (int w = 0; w < 8; w++)
      if (ic_line[w] !== img(base + 10'(w))) err++;
    check(tag, 32'(err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    int          lat, n, f0, w0, t0, b0;

    rst_n        = 1'b0;
    clk_en       = 1'b1;
    ic_go        = 1'b0;
    ic_base      = 10'h040;
    bus.dp_req   = 1'b0;
    bus.dp_we    = 1'b0;
    bus.dp_addr  = '0;
    bus.dp_wdata = '0;

    // Reset with a miss pending, then the first refill
    cyc(3);
    ic_go = 1'b1;
    cyc(1);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_dp_ready", 32'(bus.dp_ready), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_ic_clk_en", 32'(bus.ic_clk_en), 32'd0);
    t0 = track_err;
    b0 = burst_cnt;
    rst_n = 1'b1;
    #1;
    check("post_rst_frozen", 32'(bus.ic_clk_en), 32'd0);
    cyc(1);
    check("burst_ic_clk_en", 32'(bus.ic_clk_en), 32'd1);
    check("burst_first_addr", 32'(bus.mem_addr), 32'h040);
    wait_ic_release(n);
    check("burst_release_seen", 32'(n < 200), 32'd1);
    cyc(1);
    check("burst_len", 32'(burst_cnt - b0), 32'd17);
    check("burst_track", 32'(track_err - t0), 32'd0);
    check("line040_w0", 32'(ic_line[0]), 32'(img(10'h040)));
    check("line040_w7", 32'(ic_line[7]), 32'(img(10'h047)));
    check_line("line040", 10'h040);

    // Plain read
    w0 = we_cnt;
    dp_txn(1'b0, 10'h155, 16'h0000, rd, lat);
    check("rd_latency", 32'(lat), 32'd2);
    check("rd_data", 32'(rd), 32'hBEEF);
    check("rd_no_we", 32'(we_cnt - w0), 32'd0);

    // Write then read back
    cyc(1);
    w0 = we_cnt;
    dp_txn(1'b1, 10'h3FF, 16'h1234, rd, lat);
    check("wr_latency", 32'(lat), 32'd2);
    check("wr_we_cycles", 32'(we_cnt - w0), 32'd1);
    cyc(1);
    dp_txn(1'b0, 10'h3FF, 16'h0000, rd, lat);
    check("wr_readback", 32'(rd), 32'h1234);

    // Simultaneous requests after reset: data, burst, data
    cyc(1);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    ic_base      = 10'h080;
    ic_go        = 1'b1;
    bus.dp_req   = 1'b1;
    bus.dp_we    = 1'b0;
    bus.dp_addr  = 10'h155;
    cyc(1);
    f0 = frozen_cnt;
    check("sim_dp_first", 32'(bus.mem_addr), 32'h155);
    cyc(1);
    check("sim_dp_ready", 32'(bus.dp_ready), 32'd1);
    check("sim_dp_data", 32'(bus.dp_rdata), 32'hBEEF);
    bus.dp_req = 1'b0;
    cyc(1);
    bus.dp_req  = 1'b1;
    bus.dp_addr = 10'h3FF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.ic_mreq && bus.ic_clk_en) && n < 60);
    check("sim_burst_start", 32'(n), 32'd1);
    check("sim_frozen", 32'(frozen_cnt - f0), 32'd3);
    // 18 burst cycles + IDLE + DP_ADDR before dp_ready
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.dp_ready && n < 60);
    check("sim_dp2_wait", 32'(n), 32'd20);
    check("sim_dp2_data", 32'(bus.dp_rdata), 32'h1234);
    bus.dp_req = 1'b0;
    ic_go      = 1'b0;
    check_line("line080", 10'h080);

    // Data request arriving mid-burst
    cyc(1);
    ic_base = 10'h0C0;
    ic_go   = 1'b1;
    t0      = track_err;
    cyc(6);
    bus.dp_req  = 1'b1;
    bus.dp_we   = 1'b0;
    bus.dp_addr = 10'h155;
    wait_ic_release(n);
    check("mid_release_seen", 32'(n < 200), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.dp_ready && n < 60);
    check("mid_dp_wait", 32'(n), 32'd3);
    check("mid_dp_data", 32'(bus.dp_rdata), 32'hBEEF);
    bus.dp_req = 1'b0;
    check("mid_track", 32'(track_err - t0), 32'd0);
    check_line("line0c0", 10'h0C0);

    // Clock-enable hold and asynchronous reset during a burst
    cyc(1);
    ic_base = 10'h100;
    ic_go   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.ic_mreq && bus.ic_clk_en) && n < 60);
    cyc(3);
    clk_en = 1'b0;
    cyc(2);
    check("hold_ic_clk_en", 32'(bus.ic_clk_en), 32'd0);
    check("hold_addr", 32'(bus.mem_addr), 32'(bus.ic_addr));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_addr", 32'(bus.mem_addr), 32'd0);
    check("arst_we", 32'(bus.mem_we), 32'd0);
    check("arst_ic_clk_en", 32'(bus.ic_clk_en), 32'd0);
    clk_en = 1'b1;
    cyc(1);
    clk_en = 1'b0;
    rst_n  = 1'b1;
    cyc(2);
    check("held_idle_addr", 32'(bus.mem_addr), 32'd0);
    check("held_idle_en", 32'(bus.ic_clk_en), 32'd0);
    clk_en = 1'b1;
    cyc(1);
    check("regrant_en", 32'(bus.ic_clk_en), 32'd1);
    check("regrant_addr", 32'(bus.mem_addr), 32'(bus.ic_addr));
    wait_ic_release(n);
    check("final_release_seen", 32'(n < 200), 32'd1);
    cyc(2);
    check("final_idle_addr", 32'(bus.mem_addr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
